// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause and EPC, plus the Count/Compare
// timer and interrupt merge that feed the exception unit.
module cp0_regfile #(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  read_addr,
  output logic [31:0] read_data,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [5:0]  hw_int,
  input  logic        exp_en,
  input  logic        exl_clean,
  input  logic [4:0]  exp_code,
  input  logic [31:0] exp_epc,
  input  logic        exp_bd,
  input  logic [31:0] exp_bad_vaddr,
  input  logic        exp_bad_vaddr_wen,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam int          DW           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(COUNT_DIV - 1);

  logic [31:0]   r_badvaddr;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic [31:0]   r_status;
  logic [31:0]   r_epc;
  logic          r_bd;
  logic          r_ti;
  logic [7:0]    r_ip;
  logic [4:0]    r_exccode;
  logic [DW-1:0] r_div;
  logic          r_count_chg;

  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;
  logic w_tick;
  logic w_match;
  logic w_ti_next;

  assign w_wr_count   = write_en && (write_addr == A_COUNT);
  assign w_wr_compare = write_en && (write_addr == A_COMPARE);
  assign w_wr_status  = write_en && (write_addr == A_STATUS);
  assign w_wr_cause   = write_en && (write_addr == A_CAUSE);
  assign w_wr_epc     = write_en && (write_addr == A_EPC);
  assign w_tick       = (r_div == DIV_LAST);

  // A zero Compare only matches on a fresh Count value, so Count=Compare=0 after reset stays quiet.
  assign w_match   = (r_count == r_compare) && ((r_compare != 32'd0) || r_count_chg);
  assign w_ti_next = w_wr_compare ? 1'b0 : (r_ti | w_match);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr  <= '0;
      r_count     <= '0;
      r_compare   <= '0;
      r_status    <= STATUS_RESET;
      r_epc       <= '0;
      r_bd        <= 1'b0;
      r_ti        <= 1'b0;
      r_ip        <= '0;
      r_exccode   <= '0;
      r_div       <= '0;
      r_count_chg <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= write_data;
        r_div   <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_div   <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end
      r_count_chg <= w_wr_count | w_tick;

      if (w_wr_compare) r_compare <= write_data;
      r_ti      <= w_ti_next;
      r_ip[7:2] <= {hw_int[5] | w_ti_next, hw_int[4:0]};
      if (w_wr_cause)  r_ip[1:0] <= write_data[9:8];
      if (w_wr_status) r_status <= (r_status & ~STATUS_WMASK) | (write_data & STATUS_WMASK);
      if (w_wr_epc)    r_epc <= write_data;

      // Exception commit and eret override mtc0 on the fields they own (later assignment wins).
      if (exp_en) begin
        r_status[1] <= 1'b1;
        r_exccode   <= exp_code;
        if (!r_status[1]) begin
          r_epc <= exp_epc;
          r_bd  <= exp_bd;
        end
        if (exp_bad_vaddr_wen) r_badvaddr <= exp_bad_vaddr;
      end else if (exl_clean) begin
        r_status[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    read_data = 32'd0;
    case (read_addr)
      A_BADVADDR: read_data = r_badvaddr;
      A_COUNT:    read_data = r_count;
      A_COMPARE:  read_data = r_compare;
      A_STATUS:   read_data = r_status;
      A_CAUSE:    read_data = {r_bd, r_ti, 14'd0, r_ip, 1'b0, r_exccode, 2'b00};
      A_EPC:      read_data = r_epc;
      default:    read_data = 32'd0;
    endcase
  end

  assign epc_address     = w_wr_epc ? write_data : r_epc;
  assign allow_interrupt = r_status[0] & ~r_status[1];
  assign interrupt_flag  = r_ip & r_status[15:8];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, timer, exceptions, eret, same-cycle priority, interrupts.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr;
  logic [31:0] read_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [5:0]  hw_int;
  logic        exp_en;
  logic        exl_clean;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        exp_bad_vaddr_wen;
  logic [31:0] epc_address;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;

  int n_cmp  = 0;
  int n_fail = 0;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(read_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .hw_int(hw_int), .exp_en(exp_en), .exl_clean(exl_clean), .exp_code(exp_code),
    .exp_epc(exp_epc), .exp_bd(exp_bd), .exp_bad_vaddr(exp_bad_vaddr),
    .exp_bad_vaddr_wen(exp_bad_vaddr_wen), .epc_address(epc_address),
    .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; samples are taken at least 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    read_addr = a;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic set_exp(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                         input logic [31:0] bva, input logic bva_wen);
    exp_en = 1'b1; exp_code = code; exp_epc = epc; exp_bd = bd;
    exp_bad_vaddr = bva; exp_bad_vaddr_wen = bva_wen;
  endtask

  task automatic clr_exp();
    exp_en = 1'b0; exp_bad_vaddr_wen = 1'b0;
  endtask

  task automatic eret();
    exl_clean = 1'b1;
    tick();
    exl_clean = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0; hw_int = '0;
    exp_en = 1'b0; exl_clean = 1'b0; exp_code = '0; exp_epc = '0; exp_bd = 1'b0;
    exp_bad_vaddr = '0; exp_bad_vaddr_wen = 1'b0; read_addr = '0;
    tick(); tick();
    rst = 1'b0;
    rd(5'd12); n_cmp++;
    if (read_data !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", read_data, 32'h0040_0000); end
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_cause got=%h exp=0", read_data); end
    rd(5'd14); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", read_data); end
    n_cmp++;
    if (epc_address !== 32'h0) begin n_fail++; $display("FAIL reset_epc_address got=%h exp=0", epc_address); end
    n_cmp++;
    if (allow_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_allow got=%b exp=0", allow_interrupt); end
    n_cmp++;
    if (interrupt_flag !== 8'h00) begin n_fail++; $display("FAIL reset_flag got=%h exp=00", interrupt_flag); end
  endtask

  task automatic test_timer();
    mtc0(5'd9, 32'd0);              // cycle 0: Count=0, divider=0
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 0; i < 7; i++) tick();
    rd(5'd9); n_cmp++;
    if (read_data !== 32'd4) begin n_fail++; $display("FAIL timer_count_c9 got=%0d exp=4", read_data); end
    tick();
    rd(5'd9); n_cmp++;
    if (read_data !== 32'd5) begin n_fail++; $display("FAIL timer_count_c10 got=%0d exp=5", read_data); end
    n_cmp++;
    if (interrupt_flag !== 8'h00) begin n_fail++; $display("FAIL timer_flag_c10 got=%h exp=00", interrupt_flag); end
    tick();
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h4000_8000) begin n_fail++; $display("FAIL timer_cause_ti got=%h exp=%h", read_data, 32'h4000_8000); end
    n_cmp++;
    if (interrupt_flag !== 8'h80) begin n_fail++; $display("FAIL timer_flag_ti got=%h exp=80", interrupt_flag); end
    mtc0(5'd11, 32'd100);
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL timer_ti_clear got=%h exp=0", read_data); end
    n_cmp++;
    if (interrupt_flag !== 8'h00) begin n_fail++; $display("FAIL timer_flag_clear got=%h exp=00", interrupt_flag); end
    rd(5'd9); n_cmp++;
    if (read_data !== 32'd6) begin n_fail++; $display("FAIL timer_count_c12 got=%0d exp=6", read_data); end
    mtc0(5'd11, 32'hFFFF_FFF0);
  endtask

  task automatic test_count_wrap();
    mtc0(5'd9, 32'hFFFF_FFFE);
    rd(5'd9); n_cmp++;
    if (read_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_load got=%h exp=fffffffe", read_data); end
    tick(); rd(5'd9); n_cmp++;
    if (read_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_div_hold got=%h exp=fffffffe", read_data); end
    tick(); rd(5'd9); n_cmp++;
    if (read_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_inc got=%h exp=ffffffff", read_data); end
    tick(); tick(); rd(5'd9); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", read_data); end
  endtask

  task automatic test_exception();
    set_exp(5'h04, 32'hbfc0_0100, 1'b1, 32'h0000_1003, 1'b1);
    tick();
    clr_exp();
    rd(5'd12); n_cmp++;
    if (read_data !== 32'h0040_8003) begin n_fail++; $display("FAIL exc_status got=%h exp=%h", read_data, 32'h0040_8003); end
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h8000_0010) begin n_fail++; $display("FAIL exc_cause got=%h exp=%h", read_data, 32'h8000_0010); end
    rd(5'd14); n_cmp++;
    if (read_data !== 32'hbfc0_0100) begin n_fail++; $display("FAIL exc_epc got=%h exp=%h", read_data, 32'hbfc0_0100); end
    rd(5'd8); n_cmp++;
    if (read_data !== 32'h0000_1003) begin n_fail++; $display("FAIL exc_badvaddr got=%h exp=%h", read_data, 32'h0000_1003); end
    n_cmp++;
    if (allow_interrupt !== 1'b0) begin n_fail++; $display("FAIL exc_allow got=%b exp=0", allow_interrupt); end
    mtc0(5'd8, 32'h0000_FFFF);
    rd(5'd8); n_cmp++;
    if (read_data !== 32'h0000_1003) begin n_fail++; $display("FAIL badvaddr_ro got=%h exp=%h", read_data, 32'h0000_1003); end
    rd(5'd3); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL unimpl_read got=%h exp=0", read_data); end
  endtask

  task automatic test_nested_and_eret();
    set_exp(5'h0c, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    tick();
    clr_exp();
    rd(5'd14); n_cmp++;
    if (read_data !== 32'hbfc0_0100) begin n_fail++; $display("FAIL nest_epc got=%h exp=%h", read_data, 32'hbfc0_0100); end
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h8000_0030) begin n_fail++; $display("FAIL nest_cause got=%h exp=%h", read_data, 32'h8000_0030); end
    eret();
    rd(5'd12); n_cmp++;
    if (read_data !== 32'h0040_8001) begin n_fail++; $display("FAIL eret_status got=%h exp=%h", read_data, 32'h0040_8001); end
    n_cmp++;
    if (allow_interrupt !== 1'b1) begin n_fail++; $display("FAIL eret_allow got=%b exp=1", allow_interrupt); end
  endtask

  task automatic test_same_cycle();
    set_exp(5'h00, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 1'b0);
    write_en = 1'b1; write_addr = 5'd12; write_data = 32'h0;
    tick();
    clr_exp(); write_en = 1'b0;
    rd(5'd12); n_cmp++;
    if (read_data !== 32'h0040_0002) begin n_fail++; $display("FAIL prio_status got=%h exp=%h", read_data, 32'h0040_0002); end
    n_cmp++;
    if (allow_interrupt !== 1'b0) begin n_fail++; $display("FAIL prio_allow got=%b exp=0", allow_interrupt); end
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL prio_cause got=%h exp=0", read_data); end
    rd(5'd8); n_cmp++;
    if (read_data !== 32'h0000_1003) begin n_fail++; $display("FAIL prio_bva_hold got=%h exp=%h", read_data, 32'h0000_1003); end
    eret();
    set_exp(5'h08, 32'h0000_4000, 1'b0, 32'h0, 1'b0);
    write_en = 1'b1; write_addr = 5'd14; write_data = 32'h0000_1234;
    rd(5'd14); n_cmp++;
    if (epc_address !== 32'h0000_1234) begin n_fail++; $display("FAIL fwd_epc_address got=%h exp=%h", epc_address, 32'h0000_1234); end
    n_cmp++;
    if (read_data !== 32'h0000_2000) begin n_fail++; $display("FAIL fwd_read_old got=%h exp=%h", read_data, 32'h0000_2000); end
    tick();
    clr_exp(); write_en = 1'b0;
    rd(5'd14); n_cmp++;
    if (read_data !== 32'h0000_4000) begin n_fail++; $display("FAIL fwd_epc_reg got=%h exp=%h", read_data, 32'h0000_4000); end
    eret();
  endtask

  task automatic test_interrupts();
    hw_int = 6'b000100;
    mtc0(5'd12, 32'h0000_1001);
    n_cmp++;
    if (interrupt_flag !== 8'h10) begin n_fail++; $display("FAIL hw_flag got=%h exp=10", interrupt_flag); end
    mtc0(5'd12, 32'h0000_0001);
    n_cmp++;
    if (interrupt_flag !== 8'h00) begin n_fail++; $display("FAIL hw_masked got=%h exp=00", interrupt_flag); end
    hw_int = 6'b000000;
    mtc0(5'd12, 32'h0000_0301);
    mtc0(5'd13, 32'h0000_0200);
    n_cmp++;
    if (interrupt_flag !== 8'h02) begin n_fail++; $display("FAIL sw_flag got=%h exp=02", interrupt_flag); end
    rd(5'd13); n_cmp++;
    if (read_data !== 32'h0000_0220) begin n_fail++; $display("FAIL sw_cause got=%h exp=%h", read_data, 32'h0000_0220); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_count_wrap();
    test_exception();
    test_nested_and_eret();
    test_same_cycle();
    test_interrupts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
